// File: rtl/cond_unit.sv
// cond_unit: conditional-execution stage behind the decoder.
// Holds the NZCV flags, evaluates the condition field, and gates write and
// branch enables. Multi-cycle FP ops stall fetch, and their writes are held
// back until the op's final cycle.
// Stall tells the upstream stage to hold its instruction. Upstream keeps
// Cond, the controls and ALUControl stable while Stall=1. There is no ready
// path back: the instruction is consumed in the first cycle with Stall=0.
module cond_unit #(
    parameter int FP_LAT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       VecW,
    input  logic       VecIdxW,
    input  logic [3:0] ALUControl,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       VecWrite,
    output logic       VecIdxWrite,
    output logic       CondEx,
    output logic       Stall,
    output logic [3:0] Flags,
    output logic       state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(FP_LAT - 1);
    localparam logic MULTI = (FP_LAT > 1);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       is_fp, start, last, commit;
    logic       n, z, c, v;

    assign {n, z, c, v} = Flags;
    assign is_fp = (ALUControl == 4'b1100) || (ALUControl == 4'b0101);
    assign state_dbg = state;

    // Condition evaluation against the registered flags.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = z;
            4'b0001: CondEx = ~z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = ~c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = ~n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = ~v;
            4'b1000: CondEx = c & ~z;
            4'b1001: CondEx = ~c | z;
            4'b1010: CondEx = (n == v);
            4'b1011: CondEx = (n != v);
            4'b1100: CondEx = ~z & (n == v);
            4'b1101: CondEx = z | (n != v);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    // Next-state, counter, stall and "last cycle" decode for FP sequencing.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                start = is_fp & CondEx & MULTI;
                last  = ~is_fp | ~CondEx | ~MULTI;
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = LAT_M1;
                end
            end
            BUSY: begin
                // Inputs are ignored here; only the counter ends the op.
                last     = (cnt == 4'd1);
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // While reset is low, stall and every enable are forced to 0, even if the
    // decoder inputs are active.
    assign commit      = reset & CondEx & last;
    assign Stall       = reset & (start | ((state == BUSY) && (cnt > 4'd1)));
    assign PCSrc       = PCS & commit;
    assign RegWrite    = RegW & commit;
    assign MemWrite    = MemW & commit;
    assign VecWrite    = VecW & commit;
    assign VecIdxWrite = VecIdxW & commit;

    // FSM state and latency counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Flag register. N,Z and C,V load independently, and only on a committing
    // cycle. A flag write in the same cycle as a branch takes effect, but only
    // the next instruction sees the new flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags <= 4'b0000;
        end else if (CondEx && last) begin
            if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed testbench for cond_unit (FP_LAT=3).
module tb_cond_unit;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, VecW, VecIdxW;
    logic [3:0] ALUControl;
    logic       PCSrc, RegWrite, MemWrite, VecWrite, VecIdxWrite;
    logic       CondEx, Stall;
    logic [3:0] Flags;
    logic       state_dbg;

    int total = 0;
    int bad   = 0;

    cond_unit #(.FP_LAT(3)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .VecW(VecW),
        .VecIdxW(VecIdxW), .ALUControl(ALUControl), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .VecWrite(VecWrite),
        .VecIdxWrite(VecIdxWrite), .CondEx(CondEx), .Stall(Stall),
        .Flags(Flags), .state_dbg(state_dbg)
    );

    // Clock: 10 time-unit period. Inputs change 1 after posedge; checks run 2 later.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 0; RegW = 0; MemW = 0; VecW = 0; VecIdxW = 0;
        ALUControl = 4'b0000;
    endtask

    // Load a flag value using an AL instruction that writes all four flags.
    task automatic set_flags(input logic [3:0] f);
        idle_inputs();
        FlagW = 2'b11; ALUFlags = f;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        RegW = 1; PCS = 1; MemW = 1; ALUControl = 4'b1100;
        #2;
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        total++; if ({PCSrc, RegWrite, MemWrite, VecWrite, VecIdxWrite} !== 5'b0) begin
            bad++; $display("FAIL reset_enables got=%b exp=00000", {PCSrc, RegWrite, MemWrite, VecWrite, VecIdxWrite}); end
        total++; if (state_dbg !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", state_dbg); end
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        Cond = 4'b1110; RegW = 1; FlagW = 2'b11; ALUFlags = 4'b0100;
        #2;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL first_regwrite got=%b exp=1", RegWrite); end
        step();
        idle_inputs();
        #2;
        total++; if (Flags !== 4'b0100) begin bad++; $display("FAIL first_flags got=%b exp=0100", Flags); end
    endtask

    task automatic test_cond_gate();
        Cond = 4'b0001; RegW = 1; MemW = 1; VecW = 1; VecIdxW = 1; FlagW = 2'b11; ALUFlags = 4'b1111;
        #2;
        total++; if (CondEx !== 1'b0) begin bad++; $display("FAIL ne_condex got=%b exp=0", CondEx); end
        total++; if ({RegWrite, MemWrite, VecWrite, VecIdxWrite} !== 4'b0000) begin
            bad++; $display("FAIL ne_enables got=%b exp=0000", {RegWrite, MemWrite, VecWrite, VecIdxWrite}); end
        step();
        total++; if (Flags !== 4'b0100) begin bad++; $display("FAIL ne_flags_hold got=%b exp=0100", Flags); end
        Cond = 4'b0000; FlagW = 2'b00;
        #2;
        total++; if ({RegWrite, MemWrite, VecWrite, VecIdxWrite} !== 4'b1111) begin
            bad++; $display("FAIL eq_enables got=%b exp=1111", {RegWrite, MemWrite, VecWrite, VecIdxWrite}); end
        step();
        idle_inputs();
    endtask

    task automatic test_partial_flags();
        set_flags(4'b0000);
        FlagW = 2'b01; ALUFlags = 4'b1111;
        step();
        total++; if (Flags !== 4'b0011) begin bad++; $display("FAIL flagw01 got=%b exp=0011", Flags); end
        FlagW = 2'b10; ALUFlags = 4'b1000;
        step();
        total++; if (Flags !== 4'b1011) begin bad++; $display("FAIL flagw10 got=%b exp=1011", Flags); end
        idle_inputs();
    endtask

    // Expected CondEx per condition code, bit i = Cond i.
    task automatic test_cond_table(input logic [3:0] f, input logic [15:0] exp_tab);
        set_flags(f);
        for (int i = 0; i < 16; i++) begin
            Cond = 4'(i);
            #1;
            total++;
            if (CondEx !== exp_tab[i]) begin
                bad++; $display("FAIL cond_table flags=%b cond=%0d got=%b exp=%b", f, i, CondEx, exp_tab[i]);
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_fp_op();
        logic [2:0] exp_stall;
        logic [2:0] exp_rw;
        exp_stall = 3'b011;
        exp_rw    = 3'b100;
        Cond = 4'b1110; ALUControl = 4'b1100; RegW = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++; if (Stall !== exp_stall[i]) begin bad++; $display("FAIL fp_stall cyc=%0d got=%b exp=%b", i, Stall, exp_stall[i]); end
            total++; if (RegWrite !== exp_rw[i]) begin bad++; $display("FAIL fp_regwrite cyc=%0d got=%b exp=%b", i, RegWrite, exp_rw[i]); end
            step();
        end
        idle_inputs();
        #2;
        total++; if (state_dbg !== 1'b0) begin bad++; $display("FAIL fp_back_idle got=%b exp=0", state_dbg); end
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL fp_after_stall got=%b exp=0", Stall); end
    endtask

    task automatic test_fp_cond_fail();
        set_flags(4'b0000);
        Cond = 4'b0000; ALUControl = 4'b0101; RegW = 1;
        #2;
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL fmul_fail_stall got=%b exp=0", Stall); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL fmul_fail_regwrite got=%b exp=0", RegWrite); end
        step();
        #2;
        total++; if (state_dbg !== 1'b0) begin bad++; $display("FAIL fmul_fail_state got=%b exp=0", state_dbg); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_busy();
        set_flags(4'b1111);
        Cond = 4'b1110; ALUControl = 4'b1100; RegW = 1;
        step();
        #2;
        total++; if (Stall !== 1'b1) begin bad++; $display("FAIL busy_stall got=%b exp=1", Stall); end
        reset = 1'b0;
        #1;
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL midreset_stall got=%b exp=0", Stall); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL midreset_regwrite got=%b exp=0", RegWrite); end
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL midreset_flags got=%b exp=0000", Flags); end
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        #2;
        total++; if (state_dbg !== 1'b0) begin bad++; $display("FAIL postreset_state got=%b exp=0", state_dbg); end
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL postreset_flags got=%b exp=0000", Flags); end
    endtask

    task automatic test_branch();
        Cond = 4'b1111; PCS = 1;
        #2;
        total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL nv_pcsrc got=%b exp=0", PCSrc); end
        step();
        Cond = 4'b1110; PCS = 1; FlagW = 2'b11; ALUFlags = 4'b1000;
        #2;
        total++; if (PCSrc !== 1'b1) begin bad++; $display("FAIL al_pcsrc got=%b exp=1", PCSrc); end
        total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL branch_flags_same got=%b exp=0000", Flags); end
        step();
        idle_inputs();
        Cond = 4'b0100;
        #2;
        total++; if (Flags !== 4'b1000) begin bad++; $display("FAIL branch_flags_next got=%b exp=1000", Flags); end
        total++; if (CondEx !== 1'b1) begin bad++; $display("FAIL branch_mi_condex got=%b exp=1", CondEx); end
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #3;
        test_reset();
        test_cond_gate();
        test_partial_flags();
        // flags 1011: N=1 Z=0 C=1 V=1 -> EQ0 NE1 CS1 CC0 MI1 PL0 VS1 VC0 HI1 LS0 GE1 LT0 GT1 LE0 AL1 NV0
        test_cond_table(4'b1011, 16'b0101_0101_0101_0110);
        // flags 0100: Z=1 -> EQ1 NE0 CS0 CC1 MI0 PL1 VS0 VC1 HI0 LS1 GE1 LT0 GT0 LE1 AL1 NV0
        test_cond_table(4'b0100, 16'b0110_0110_1010_1001);
        test_fp_op();
        test_fp_cond_fail();
        test_reset_mid_busy();
        test_branch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
